branch_predictor: RTL

Parametrised branch target buffer (BTB) with a 2-bit-counter direction table and optional gshare indexing. It sits beside the IF stage of the pipelined CPU. IF performs a same-cycle lookup on the fetch PC, and the prediction is carried down the pipeline. EX resolves the branch, feeds the outcome back here, and receives a mispredict/redirect decision. This replaces the fixed predict-not-taken fetch path with learned prediction, and adds misprediction statistics.

---
 rtl/branch_predictor_if.sv | 35 +++
 rtl/branch_predictor.sv | 116 +++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolve signals shared between the CPU pipeline and
// the branch predictor.
interface branch_predictor_if #(
  parameter int WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] if_pc;
  logic                 pred_hit;
  logic                 pred_taken;
  logic [WORD_SIZE-1:0] pred_target;
  logic                 upd_valid;
  logic                 upd_is_jump;
  logic [WORD_SIZE-1:0] upd_pc;
  logic                 upd_taken;
  logic [WORD_SIZE-1:0] upd_target;
  logic                 upd_pred_taken;
  logic [WORD_SIZE-1:0] upd_pred_target;
  logic                 mispredict;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic [WORD_SIZE-1:0] branch_count;
  logic [WORD_SIZE-1:0] mispredict_count;

  modport master (
    output if_pc, upd_valid, upd_is_jump, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  if_pc, upd_valid, upd_is_jump, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit counter PHT (optional gshare indexing),
// combinational fetch lookup, resolve-time mispredict detection and statistics.
module branch_predictor #(
  parameter int       WORD_SIZE    = 16,
  parameter int       ENTRIES      = 16,
  parameter int       GSHARE       = 0,
  parameter logic [1:0] COUNTER_INIT = 2'b01
) (
  input logic              clk,
  input logic              reset,
  branch_predictor_if.slave bp
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = WORD_SIZE - IDX;
  localparam bit USE_GSHARE = (GSHARE != 0);

  logic                 valid_q  [ENTRIES];
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];
  logic                 jump_q   [ENTRIES];
  logic [1:0]           pht_q    [ENTRIES];
  logic [IDX-1:0]       ghr_q, ghr_d;
  logic [WORD_SIZE-1:0] branch_cnt_q, branch_cnt_d;
  logic [WORD_SIZE-1:0] mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX-1:0]       lk_idx, lk_pht_idx;
  logic [WORD_SIZE-1:0] lk_seq;
  logic                 lk_hit, lk_taken;

  logic [IDX-1:0]       up_idx, up_pht_idx;
  logic [TAG_W-1:0]     up_tag;
  logic                 up_hit, up_mispredict;
  logic [1:0]           pht_cur, pht_d;
  logic                 pht_we, btb_we;

  // Fetch-side lookup
  assign lk_idx     = bp.if_pc[IDX-1:0];
  assign lk_pht_idx = USE_GSHARE ? (lk_idx ^ ghr_q) : lk_idx;
  assign lk_seq     = bp.if_pc + WORD_SIZE'(1);
  assign lk_hit     = ~reset & valid_q[lk_idx] &
                      (tag_q[lk_idx] == bp.if_pc[WORD_SIZE-1:IDX]);
  assign lk_taken   = lk_hit & (jump_q[lk_idx] | pht_q[lk_pht_idx][1]);

  assign bp.pred_hit    = lk_hit;
  assign bp.pred_taken  = lk_taken;
  assign bp.pred_target = lk_taken ? target_q[lk_idx] : lk_seq;

  // Resolve-side decode
  assign up_idx     = bp.upd_pc[IDX-1:0];
  assign up_pht_idx = USE_GSHARE ? (up_idx ^ ghr_q) : up_idx;
  assign up_tag     = bp.upd_pc[WORD_SIZE-1:IDX];
  assign up_hit     = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
  assign pht_cur    = pht_q[up_pht_idx];

  assign up_mispredict = bp.upd_valid &
                         ((bp.upd_taken != bp.upd_pred_taken) |
                          (bp.upd_taken & (bp.upd_target != bp.upd_pred_target)));

  assign bp.mispredict       = up_mispredict;
  assign bp.redirect_pc      = ~bp.upd_valid ? '0 :
                               bp.upd_taken  ? bp.upd_target :
                                               bp.upd_pc + WORD_SIZE'(1);
  assign bp.branch_count     = reset ? '0 : branch_cnt_q;
  assign bp.mispredict_count = reset ? '0 : mispredict_cnt_q;

  always_comb begin
    pht_we           = bp.upd_valid & ~bp.upd_is_jump;
    btb_we           = bp.upd_valid & bp.upd_taken;
    pht_d            = pht_cur;
    ghr_d            = ghr_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;

    if (pht_we) begin
      // A freshly allocated conditional branch starts weakly taken.
      if (bp.upd_taken && !up_hit)
        pht_d = 2'b10;
      else if (bp.upd_taken)
        pht_d = (pht_cur == 2'b11) ? 2'b11 : pht_cur + 2'b01;
      else
        pht_d = (pht_cur == 2'b00) ? 2'b00 : pht_cur - 2'b01;
      ghr_d = (ghr_q << 1) | IDX'(bp.upd_taken);
    end

    if (bp.upd_valid) begin
      if (branch_cnt_q != '1)
        branch_cnt_d = branch_cnt_q + WORD_SIZE'(1);
      if (up_mispredict && mispredict_cnt_q != '1)
        mispredict_cnt_d = mispredict_cnt_q + WORD_SIZE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        pht_q[i]   <= COUNTER_INIT;
      end
      ghr_q            <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      ghr_q            <= ghr_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      if (pht_we)
        pht_q[up_pht_idx] <= pht_d;
      if (btb_we) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bp.upd_target;
        jump_q[up_idx]   <= bp.upd_is_jump;
      end
    end
  end
endmodule
